joystick_responder: RTL
=======================

Name: joystick_responder

Overview:
- Device-side end of the serial latch/pulse joystick protocol; the joystick_driver is the host side.
- On a latch from the host, snapshots an 8-bit X and an 8-bit Y position and shifts them out one bit per host pulse on data_out.
- Used as a board-level controller emulator, with its data_out wired to the driver's data_in on a GPIO loopback.
- Also used as the bus-functional device in driver simulation.

Parameters:
- NBITS, 16, bits per frame; must equal 2*8, X byte first then Y byte.
- SYNC_STAGES, 2, flip-flop stages on the latch and pulse inputs; allowed 2..3.
- IDLE_BIT, 1'b1, level driven on data_out when no frame bit is valid.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset_n  input  1  asynchronous, active-low reset.
- latch  input  1  host latch, asynchronous to clk, active high.
- pulse  input  1  host shift clock, asynchronous to clk; bit advances on its rising edge.
- positionX  input  8  X value to report; sampled only at latch.
- positionY  input  8  Y value to report; sampled only at latch.
- data_out  output  1  serial data to the host.
- busy  output  1  high from latch capture until the last bit is consumed.
- frame_done  output  1  one-clk strobe when the NBITS-th pulse edge is consumed.
- frame_count  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=IDLE, shift_reg=0, bit_cnt=0.
  - data_out=IDLE_BIT, busy=0, frame_done=0, frame_count=0.
  - Sync chains cleared to 0.
- Input synchronisation: latch and pulse each pass through SYNC_STAGES flops plus one history flop. A rise is sync_out & ~hist.
- States:
  - IDLE -> LATCHED on latch rise.
  - LATCHED -> SHIFT on latch fall (sync-domain low).
  - SHIFT -> IDLE after the NBITS-th pulse rise.
  - Any state -> LATCHED on latch rise; this re-snapshots and aborts the current frame with no frame_done.
- Latch rise:
  - shift_reg <= {positionX, positionY}, bit_cnt <= 0, busy <= 1.
  - data_out <= positionX[7] on the next clk.
- In LATCHED: data_out held at bit 15 continuously; pulse rises are ignored.
- Pulse rise in SHIFT:
  - shift_reg shifts left, filling with IDLE_BIT; bit_cnt increments.
  - data_out presents the new shift_reg[15] one clk after detection.
  - Host samples bit k (k=0..15, MSB-first) before pulse edge k; order is X[7..0] then Y[7..0].
- On the pulse rise with bit_cnt==NBITS-1:
  - frame_done=1 for exactly one clk; frame_count increments; busy <= 0; state -> IDLE.
  - data_out <= IDLE_BIT.
- Pulse rise in IDLE: ignored; data_out stays IDLE_BIT; no counter change.
- Latch rise and pulse rise detected in the same clk: the latch wins and the pulse is discarded.
- Latency: data_out reflects a new bit within SYNC_STAGES+2 clk of the input edge. The host's half-pulse must exceed this; it is met by the clock-divided driver.
- bit_cnt width: $clog2(NBITS)+1; it never exceeds NBITS.
- positionX/positionY changes outside the latch-capture cycle have no effect on the frame in flight.
- Async reset asserted mid-frame: all outputs return to reset values immediately. The next frame requires a fresh latch.

Decomposition:
- Shared package joystick_pkg:
  - constants JS_AXIS_BITS=8 and JS_FRAME_BITS=16.
  - state enum js_resp_state_t {IDLE, LATCHED, SHIFT}.
  - The host-side joystick_driver imports the same constants.
- One natural sub-module: edge_sync, an N-stage synchroniser plus rising-edge detector with reset_n.
  - Instantiated twice (latch, pulse).
  - Parameterised by SYNC_STAGES.

Test Plan:
- Reset with reset_n=0, latch and pulse toggling -> data_out=1, busy=0, frame_count=0 throughout. Release -> still idle.
- positionX=8'hA5, positionY=8'h3C, latch pulse, then 16 pulses (pulse period 40 clk) -> sampled bits are 1010_0101_0011_1100. frame_done strobes once; frame_count=1; data_out=1 afterwards.
- Change positionX to 8'hFF after latch, mid-frame -> the frame still reports A5/3C.
- Re-latch after 5 pulses with X=8'h0F, Y=8'hF0 -> no frame_done; the next 16 bits are 0000_1111_1111_0000; frame_count increments by 1 only.
- 17th and 18th pulses after frame end, and pulses with no latch -> data_out stays 1; frame_count unchanged.
- 256 complete frames -> frame_count wraps to 0. Assert reset_n at bit 9 -> immediate idle outputs; the next latched frame is correct.

Source files
------------

// File: rtl/joystick_responder_pkg.sv
// Shared constants and types for the serial latch/pulse joystick protocol,
// imported by both the device-side responder and the host-side driver.
package joystick_pkg;

    localparam int JS_AXIS_BITS  = 8;
    localparam int JS_FRAME_BITS = 2 * JS_AXIS_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        SHIFT
    } js_resp_state_t;

    // A frame goes out MSB-first, X byte ahead of Y byte.
    function automatic logic [JS_FRAME_BITS-1:0] js_pack_frame(
        input logic [JS_AXIS_BITS-1:0] x,
        input logic [JS_AXIS_BITS-1:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/joystick_responder_if.sv
// Latch/pulse joystick bus: the host drives latch, pulse and positions,
// the device answers with serial data and frame status.
interface joystick_responder_if;
    import joystick_pkg::*;

    logic                    latch;
    logic                    pulse;
    logic [JS_AXIS_BITS-1:0] positionX;
    logic [JS_AXIS_BITS-1:0] positionY;
    logic                    data_out;
    logic                    busy;
    logic                    frame_done;
    logic [7:0]              frame_count;

    modport master (
        output latch, pulse, positionX, positionY,
        input  data_out, busy, frame_done, frame_count
    );

    modport slave (
        input  latch, pulse, positionX, positionY,
        output data_out, busy, frame_done, frame_count
    );

endinterface

// File: rtl/joystick_responder_edge_sync.sv
// Multi-stage synchroniser for an asynchronous input, with a history flop
// for single-clock rising-edge detection in the clk domain.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/joystick_responder.sv
// Device side of the latch/pulse joystick protocol: snapshots X/Y on latch
// and shifts the 16-bit frame out MSB-first, one bit per host pulse.
module joystick_responder
    import joystick_pkg::*;
#(
    parameter int   NBITS       = JS_FRAME_BITS,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_BIT    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    joystick_responder_if.slave bus
);

    localparam int CNT_W = $clog2(NBITS) + 1;

    logic [1:0]       rstSync_q;
    logic             rstInt_n;
    logic             latchLevel;
    logic             latchRise;
    logic             pulseRise;
    logic             pulseLevel_unused;

    js_resp_state_t   state_q, state_d;
    logic [NBITS-1:0] shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             dataOut_q, dataOut_d;
    logic             busy_q, busy_d;
    logic             frameDone_q, frameDone_d;
    logic [7:0]       frameCount_q, frameCount_d;

    // Reset asserts immediately but releases only on a clk edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    edge_sync #(.STAGES(SYNC_STAGES)) u_latchSync (
        .clk     (clk),
        .rst_n_i (rstInt_n),
        .d_i     (bus.latch),
        .level_o (latchLevel),
        .rise_o  (latchRise)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_pulseSync (
        .clk     (clk),
        .rst_n_i (rstInt_n),
        .d_i     (bus.pulse),
        .level_o (pulseLevel_unused),
        .rise_o  (pulseRise)
    );

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q      <= IDLE;
            shiftReg_q   <= '0;
            bitCnt_q     <= '0;
            dataOut_q    <= IDLE_BIT;
            busy_q       <= 1'b0;
            frameDone_q  <= 1'b0;
            frameCount_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            shiftReg_q   <= shiftReg_d;
            bitCnt_q     <= bitCnt_d;
            dataOut_q    <= dataOut_d;
            busy_q       <= busy_d;
            frameDone_q  <= frameDone_d;
            frameCount_q <= frameCount_d;
        end
    end

    // A latch rise takes priority over everything, including a coincident pulse.
    always_comb begin
        state_d      = state_q;
        shiftReg_d   = shiftReg_q;
        bitCnt_d     = bitCnt_q;
        dataOut_d    = dataOut_q;
        busy_d       = busy_q;
        frameDone_d  = 1'b0;
        frameCount_d = frameCount_q;

        if (latchRise) begin
            state_d    = LATCHED;
            shiftReg_d = js_pack_frame(bus.positionX, bus.positionY);
            bitCnt_d   = '0;
            busy_d     = 1'b1;
            dataOut_d  = bus.positionX[JS_AXIS_BITS-1];
        end else begin
            case (state_q)
                IDLE: begin
                    dataOut_d = IDLE_BIT;
                end
                LATCHED: begin
                    dataOut_d = shiftReg_q[NBITS-1];
                    if (!latchLevel) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pulseRise) begin
                        shiftReg_d = {shiftReg_q[NBITS-2:0], IDLE_BIT};
                        bitCnt_d   = bitCnt_q + CNT_W'(1);
                        dataOut_d  = shiftReg_q[NBITS-2];
                        if (bitCnt_q == CNT_W'(NBITS - 1)) begin
                            state_d      = IDLE;
                            busy_d       = 1'b0;
                            frameDone_d  = 1'b1;
                            frameCount_d = frameCount_q + 8'd1;
                            dataOut_d    = IDLE_BIT;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.data_out    = dataOut_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frameDone_q;
    assign bus.frame_count = frameCount_q;

endmodule
